logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 87 ++++++++
 tb/tb_logic_unit_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter sharing one bitwise logic unit between two requesters
module logic_unit_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state_q, state_d;
    logic last_grant_q, last_grant_d, id_q, id_d, rsp_valid_q, rsp_valid_d, grant, idle;
    logic [1:0] op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        grant        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        idle         = rst_n && (state_q == IDLE);
        req0_ready   = idle && req0_valid && !grant;
        req1_ready   = idle && req1_valid && grant;
        case (state_q)
            IDLE: if (req0_valid || req1_valid) begin
                state_d = EXEC;
                id_d    = grant;
                op_d    = grant ? req1_op : req0_op;
                a_d     = grant ? req1_a : req0_a;
                b_d     = grant ? req1_b : req0_b;
            end
            EXEC: begin
                result_d    = op_q == 2'b00 ? (a_q & b_q) :
                              op_q == 2'b01 ? (a_q | b_q) :
                              op_q == 2'b10 ? (a_q ^ b_q) : ~a_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                state_d      = IDLE;
                rsp_valid_d  = 1'b0;
                last_grant_d = id_q;
            end
            default: state_d = IDLE;
        endcase
    end
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed stimulus checked against a behavioural model and literal expectations
module tb_logic_unit_arbiter;
    logic clk = 0, rst_n = 0;
    logic req0_valid = 0, req1_valid = 0, rsp_ready = 1;
    logic [1:0] req0_op = 0, req1_op = 0;
    logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [3:0] rsp_result;
    int tests = 0, fails = 0;
    bit run = 0;

    logic_unit_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Model: phase 0 waiting for a request, 1 computing, 2 presenting a response
    int ph = 0;
    bit m_last = 1, m_id = 0;
    logic [3:0] m_res = 0;

    function automatic bit pick();
        return (req0_valid && req1_valid) ? !m_last : req1_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0;
            m_last <= 1;
        end else if (ph == 0) begin
            if (req0_valid || req1_valid) begin
                m_id  <= pick();
                m_res <= pick() ? alu(req1_op, req1_a, req1_b) : alu(req0_op, req0_a, req0_b);
                ph    <= 1;
            end
        end else if (ph == 1) ph <= 2;
        else if (rsp_ready) begin
            m_last <= m_id;
            ph     <= 0;
        end
    end

    always @(negedge clk) if (run) begin
        check("model_ready0", req0_ready, rst_n && ph == 0 && req0_valid && !pick());
        check("model_ready1", req1_ready, rst_n && ph == 0 && req1_valid && pick());
        check("model_rsp_valid", rsp_valid, rst_n && ph == 2);
        if (rsp_valid && ph == 2) begin
            check("model_rsp_id", rsp_id, m_id);
            check("model_rsp_result", rsp_result, m_res);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int k = 0;
        while (!rsp_valid && k < max) begin
            @(negedge clk);
            k++;
        end
        check("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        logic [3:0] sweep [4];
        logic [3:0] held;
        bit ids [$];
        sweep = '{4'b0000, 4'b1111, 4'b1111, 4'b1100};
        run = 1;
        req0_valid = 1;
        #3;
        check("rst_ready0", req0_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        req0_valid = 0;
        step();
        rst_n = 1;
        step();
        // single OR, operands disturbed after acceptance
        req0_valid = 1; req0_op = 2'b01; req0_a = 4'b1001; req0_b = 4'b0101;
        @(negedge clk);
        check("or_ready0", req0_ready, 1);
        step();
        req0_valid = 0; req0_a = 4'b0000;
        @(negedge clk);
        check("or_exec_valid", rsp_valid, 0);
        @(negedge clk);
        check("or_rsp_valid", rsp_valid, 1);
        check("or_rsp_id", rsp_id, 0);
        check("or_rsp_result", rsp_result, 4'b1101);
        step();
        for (int i = 0; i < 4; i++) begin
            req1_valid = 1; req1_op = 2'(i); req1_a = 4'b0011; req1_b = 4'b1100;
            step();
            req1_valid = 0;
            @(negedge clk);
            @(negedge clk);
            check("sweep_valid", rsp_valid, 1);
            check("sweep_id", rsp_id, 1);
            check("sweep_result", rsp_result, sweep[i]);
            step();
        end
        req0_valid = 1; req0_op = 2'b00; req0_a = 4'b1100; req0_b = 4'b1010;
        req1_valid = 1; req1_op = 2'b10; req1_a = 4'b0110; req1_b = 4'b0011;
        for (int k = 0; k < 20 && ids.size() < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) ids.push_back(rsp_id);
        end
        check("rr_count", ids.size(), 4);
        for (int i = 0; i < ids.size() && i < 4; i++) check("rr_id", ids[i], i % 2);
        step();
        rsp_ready = 0;
        @(negedge clk);
        wait_valid(10);
        held = rsp_result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, held);
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
        end
        step();
        rsp_ready = 1; req0_valid = 0; req1_valid = 0;
        step();
        @(negedge clk);
        check("bp_release", rsp_valid, 0);
        step();
        rsp_ready = 0;
        req1_valid = 1; req1_op = 2'b10; req1_a = 4'b1111; req1_b = 4'b0101;
        @(negedge clk);
        wait_valid(10);
        req1_valid = 0;
        #2 rst_n = 0;
        #1;
        check("rst_resp_valid", rsp_valid, 0);
        check("rst_resp_result", rsp_result, 0);
        step();
        rst_n = 1;
        rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", rsp_valid, 0);
        end
        step();
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        check("tie_ready0", req0_ready, 1);
        check("tie_ready1", req1_ready, 0);
        step();
        req0_valid = 0; req1_valid = 0;
        repeat (4) step();
        run = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
